// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, STATUS bit map
// and the exception sequencer state encoding.
package cp0_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_BREAK   = 5'd9;
  localparam logic [4:0] EXC_TEQ     = 5'd13;

  localparam int ST_IE  = 0;
  localparam int ST_SYS = 1;
  localparam int ST_BRK = 2;
  localparam int ST_TEQ = 3;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CHECK   = 4'd1,
    S_MASKED  = 4'd2,
    S_SAVE    = 4'd3,
    S_CAUSE   = 4'd4,
    S_EPC     = 4'd5,
    S_DONE    = 4'd6,
    S_ERET_RS = 4'd7,
    S_ERET_DN = 4'd8
  } cp0_state_e;

  // Unknown exception codes have no enable bit and are therefore always masked.
  function automatic logic trap_enabled(logic [31:0] st, logic [4:0] code);
    logic en;
    en = 1'b0;
    case (code)
      EXC_SYSCALL: en = st[ST_SYS];
      EXC_BREAK:   en = st[ST_BRK];
      EXC_TEQ:     en = st[ST_TEQ];
      default:     en = 1'b0;
    endcase
    return st[ST_IE] & en;
  endfunction

endpackage

// File: rtl/cp0_exc_unit_if.sv
// Controller <-> CP0 exception unit bus.
// exc_req/eret_req are level requests held until the one-cycle exc_ack pulse;
// the requester drops them in the cycle it sees exc_ack, so no request is ever
// accepted twice.
interface cp0_exc_unit_if;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        eret_req;
  logic        mtc0_we;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_wdata;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_rdata;
  logic        busy;
  logic        exc_ack;
  logic        exc_taken;
  logic        pc_redirect_valid;
  logic [31:0] pc_redirect;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;

  modport master (
    output exc_req, exc_code, exc_pc, eret_req, mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr,
    input  mfc0_rdata, busy, exc_ack, exc_taken, pc_redirect_valid, pc_redirect,
           status, cause, epc
  );

  modport slave (
    input  exc_req, exc_code, exc_pc, eret_req, mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr,
    output mfc0_rdata, busy, exc_ack, exc_taken, pc_redirect_valid, pc_redirect,
           status, cause, epc
  );
endinterface

// File: rtl/cp0_regfile.sv
// STATUS/CAUSE/EPC/t_status storage with the MTC0 write port and MFC0 read mux.
// Sequencer updates and MTC0 writes are mutually exclusive in time (busy gating).
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] STATUS_RESET = 32'h0000_001F,
  parameter int          MASK_SHAMT   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        save_en,
  input  logic        cause_en,
  input  logic [4:0]  cause_code,
  input  logic        epc_en,
  input  logic [31:0] epc_val,
  input  logic        eret_en,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc,
  output logic [31:0] t_status
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status   <= STATUS_RESET;
      cause    <= '0;
      epc      <= '0;
      t_status <= '0;
    end else begin
      if (save_en) begin
        t_status <= status;
        status   <= status << MASK_SHAMT;
      end else if (eret_en) begin
        status <= status >> MASK_SHAMT;
      end else if (wr_en && wr_addr == CP0_STATUS) begin
        status <= wr_data;
      end

      if (cause_en)
        cause <= {25'd0, cause_code, 2'b00};
      else if (wr_en && wr_addr == CP0_CAUSE)
        cause <= wr_data;

      if (epc_en)
        epc <= epc_val;
      else if (wr_en && wr_addr == CP0_EPC)
        epc <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      CP0_STATUS: rd_data = status;
      CP0_CAUSE:  rd_data = cause;
      CP0_EPC:    rd_data = epc;
      default:    rd_data = '0;
    endcase
  end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception/ERET sequencer: Moore FSM that walks STATUS, CAUSE and EPC
// updates one per cycle and returns ack plus a PC redirect to the controller.
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0004,
  parameter logic [31:0] STATUS_RESET = 32'h0000_001F,
  parameter int          MASK_SHAMT   = 5
) (
  input  logic                clk,
  input  logic                rst,
  cp0_exc_unit_if.slave       bus,
  output cp0_state_e          dbg_state,
  output logic [31:0]         dbg_t_status
);

  cp0_state_e  state, state_nx;
  logic [4:0]  code_q;
  logic [31:0] pc_q;
  logic        save_en, cause_en, epc_en, eret_en;
  logic        busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q <= '0;
      pc_q   <= '0;
    end else if (state == S_IDLE && bus.exc_req) begin
      code_q <= bus.exc_code;
      pc_q   <= bus.exc_pc;
    end
  end

  // Exception has priority over ERET when both are requested together.
  always_comb begin
    state_nx = state;
    save_en  = 1'b0;
    cause_en = 1'b0;
    epc_en   = 1'b0;
    eret_en  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.exc_req)       state_nx = S_CHECK;
        else if (bus.eret_req) state_nx = S_ERET_RS;
      end
      S_CHECK:   state_nx = trap_enabled(bus.status, code_q) ? S_SAVE : S_MASKED;
      S_MASKED:  state_nx = S_IDLE;
      S_SAVE:    begin save_en  = 1'b1; state_nx = S_CAUSE;   end
      S_CAUSE:   begin cause_en = 1'b1; state_nx = S_EPC;     end
      S_EPC:     begin epc_en   = 1'b1; state_nx = S_DONE;    end
      S_DONE:    state_nx = S_IDLE;
      S_ERET_RS: begin eret_en  = 1'b1; state_nx = S_ERET_DN; end
      S_ERET_DN: state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.exc_ack           = 1'b0;
    bus.exc_taken         = 1'b0;
    bus.pc_redirect_valid = 1'b0;
    bus.pc_redirect       = '0;
    case (state)
      S_MASKED: bus.exc_ack = 1'b1;
      S_DONE: begin
        bus.exc_ack           = 1'b1;
        bus.exc_taken         = 1'b1;
        bus.pc_redirect_valid = 1'b1;
        bus.pc_redirect       = EXC_VECTOR;
      end
      S_ERET_DN: begin
        bus.exc_ack           = 1'b1;
        bus.exc_taken         = 1'b1;
        bus.pc_redirect_valid = 1'b1;
        bus.pc_redirect       = bus.epc;
      end
      default: ;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign bus.busy  = busy;
  assign dbg_state = state;

  cp0_regfile #(
    .STATUS_RESET (STATUS_RESET),
    .MASK_SHAMT   (MASK_SHAMT)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (bus.mtc0_we && !busy),
    .wr_addr    (bus.mtc0_addr),
    .wr_data    (bus.mtc0_wdata),
    .save_en    (save_en),
    .cause_en   (cause_en),
    .cause_code (code_q),
    .epc_en     (epc_en),
    .epc_val    (pc_q),
    .eret_en    (eret_en),
    .rd_addr    (bus.mfc0_addr),
    .rd_data    (bus.mfc0_rdata),
    .status     (bus.status),
    .cause      (bus.cause),
    .epc        (bus.epc),
    .t_status   (dbg_t_status)
  );

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Self-checking bench for cp0_exc_unit: expected ack records are queued when a
// request is driven and compared when the unit acknowledges it.
module tb_cp0_exc_unit;
  import cp0_pkg::*;

  logic        clk;
  logic        rst;
  cp0_state_e  dbg_state;
  logic [31:0] dbg_t_status;
  int          n_checks;
  int          n_fail;

  // {latency[3:0], taken, redirect_valid, redirect[31:0]}
  logic [37:0] exp_q[$];

  cp0_exc_unit_if bus();

  cp0_exc_unit dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .dbg_state    (dbg_state),
    .dbg_t_status (dbg_t_status)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic push_exp(input int lat, input bit taken, input bit rv, input logic [31:0] redir);
    exp_q.push_back({4'(lat), taken, rv, redir});
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    bus.mtc0_we    = 1'b1;
    bus.mtc0_addr  = addr;
    bus.mtc0_wdata = data;
    tick();
    bus.mtc0_we = 1'b0;
  endtask

  task automatic mfc0_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    bus.mfc0_addr = addr;
    #1;
    check_eq(tag, bus.mfc0_rdata, exp);
  endtask

  task automatic start_exc(input logic [4:0] code, input logic [31:0] pc);
    bus.exc_req  = 1'b1;
    bus.exc_code = code;
    bus.exc_pc   = pc;
  endtask

  // Waits (bounded) for exc_ack, then pops and compares the oldest expectation.
  task automatic collect_ack(input int start_n, input bit drop_exc, input bit drop_eret);
    int          n;
    bit          seen;
    logic [37:0] e;
    n    = start_n;
    seen = 1'b0;
    while (!seen && n < 20) begin
      tick();
      n++;
      bus.mtc0_we = 1'b0;
      if (bus.exc_ack) seen = 1'b1;
    end
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check_eq("ack_seen", 32'(seen), 32'd1);
    if (seen) begin
      check_eq("ack_latency", 32'(n), 32'(e[37:34]));
      check_eq("exc_taken", 32'(bus.exc_taken), 32'(e[33]));
      check_eq("pc_redirect_valid", 32'(bus.pc_redirect_valid), 32'(e[32]));
      check_eq("pc_redirect", bus.pc_redirect, e[31:0]);
    end
    if (drop_exc)  bus.exc_req  = 1'b0;
    if (drop_eret) bus.eret_req = 1'b0;
  endtask

  initial begin
    int acks;
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b0;
    bus.exc_req    = 1'b0;
    bus.exc_code   = '0;
    bus.exc_pc     = '0;
    bus.eret_req   = 1'b0;
    bus.mtc0_we    = 1'b0;
    bus.mtc0_addr  = '0;
    bus.mtc0_wdata = '0;
    bus.mfc0_addr  = CP0_STATUS;
    tick();
    tick();

    // reset state
    check_eq("rst_status", bus.status, 32'h0000_001F);
    check_eq("rst_cause", bus.cause, 32'h0);
    check_eq("rst_epc", bus.epc, 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    check_eq("rst_ack", 32'(bus.exc_ack), 32'h0);
    check_eq("rst_redirect", bus.pc_redirect, 32'h0);
    check_eq("rst_mfc0_status", bus.mfc0_rdata, 32'h0000_001F);
    rst = 1'b1;
    tick();

    // SYSCALL taken
    push_exp(5, 1'b1, 1'b1, 32'h0000_0004);
    start_exc(EXC_SYSCALL, 32'h0040_0010);
    collect_ack(0, 1'b1, 1'b0);
    check_eq("sys_epc", bus.epc, 32'h0040_0010);
    check_eq("sys_cause", bus.cause, 32'h0000_0020);
    check_eq("sys_status", bus.status, 32'h0000_03E0);
    check_eq("sys_t_status", dbg_t_status, 32'h0000_001F);
    tick();
    check_eq("sys_idle_busy", 32'(bus.busy), 32'h0);

    // ERET back
    push_exp(2, 1'b1, 1'b1, 32'h0040_0010);
    bus.eret_req = 1'b1;
    collect_ack(0, 1'b0, 1'b1);
    tick();
    check_eq("eret_status", bus.status, 32'h0000_001F);

    // TEQ masked after narrowing STATUS
    mtc0(CP0_STATUS, 32'h0000_0007);
    mfc0_check("mfc0_status_new", CP0_STATUS, 32'h0000_0007);
    push_exp(2, 1'b0, 1'b0, 32'h0);
    start_exc(EXC_TEQ, 32'h0040_0100);
    collect_ack(0, 1'b1, 1'b0);
    tick();
    check_eq("teq_cause", bus.cause, 32'h0000_0020);
    check_eq("teq_epc", bus.epc, 32'h0040_0010);
    check_eq("teq_status", bus.status, 32'h0000_0007);

    // MTC0 to a non-CP0 register number is ignored
    mtc0(5'd5, 32'hFFFF_FFFF);
    check_eq("mtc0_bad_status", bus.status, 32'h0000_0007);
    mfc0_check("mfc0_addr5", 5'd5, 32'h0);
    mfc0_check("mfc0_cause", CP0_CAUSE, 32'h0000_0020);

    // BREAK and ERET together: BREAK first, held ERET follows after IDLE
    push_exp(5, 1'b1, 1'b1, 32'h0000_0004);
    push_exp(3, 1'b1, 1'b1, 32'h0040_1000);
    start_exc(EXC_BREAK, 32'h0040_1000);
    bus.eret_req = 1'b1;
    collect_ack(0, 1'b1, 1'b0);
    check_eq("brk_cause", bus.cause, 32'h0000_0024);
    check_eq("brk_status", bus.status, 32'h0000_00E0);
    collect_ack(0, 1'b0, 1'b1);
    tick();
    check_eq("brk_eret_status", bus.status, 32'h0000_0007);

    // MTC0 in the same IDLE cycle as exc_req: CHECK sees the new STATUS
    push_exp(5, 1'b1, 1'b1, 32'h0000_0004);
    bus.mtc0_we    = 1'b1;
    bus.mtc0_addr  = CP0_STATUS;
    bus.mtc0_wdata = 32'h0000_0009;
    start_exc(EXC_TEQ, 32'h0040_2000);
    collect_ack(0, 1'b1, 1'b0);
    check_eq("same_cyc_status", bus.status, 32'h0000_0120);
    check_eq("same_cyc_cause", bus.cause, 32'h0000_0034);
    check_eq("same_cyc_epc", bus.epc, 32'h0040_2000);
    tick();

    // reset aborts a sequence in SAVE
    mtc0(CP0_STATUS, 32'h0000_001F);
    start_exc(EXC_SYSCALL, 32'h0000_0500);
    for (int i = 0; i < 10 && dbg_state != S_SAVE; i++) tick();
    check_eq("reached_save", 32'(dbg_state), 32'(S_SAVE));
    rst = 1'b0;
    #1;
    check_eq("abort_status", bus.status, 32'h0000_001F);
    check_eq("abort_state", 32'(dbg_state), 32'(S_IDLE));
    check_eq("abort_epc", bus.epc, 32'h0);
    bus.exc_req = 1'b0;
    tick();
    rst  = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.exc_ack) acks++;
    end
    check_eq("abort_no_ack", 32'(acks), 32'h0);

    // MTC0 while busy is dropped (unknown code -> masked sequence)
    push_exp(2, 1'b0, 1'b0, 32'h0);
    start_exc(5'd0, 32'h0000_0600);
    tick();
    check_eq("busy_during_seq", 32'(bus.busy), 32'h1);
    bus.mtc0_we    = 1'b1;
    bus.mtc0_addr  = CP0_EPC;
    bus.mtc0_wdata = 32'hDEAD_BEEF;
    collect_ack(1, 1'b1, 1'b0);
    tick();
    check_eq("busy_mtc0_epc", bus.epc, 32'h0);
    mfc0_check("busy_mfc0_epc", CP0_EPC, 32'h0);
    check_eq("final_status", bus.status, 32'h0000_001F);

    check_eq("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
